// File: rtl/comp_arbiter_pkg.sv
// comp_arbiter_pkg: shared lane-index type and default sizing for comp_arbiter
package comp_arbiter_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int TAG_DEPTH_DEF = 4;
  typedef logic [$clog2(NUM_REQ_DEF)-1:0] lane_idx_t;
endpackage

// File: rtl/comp_arbiter_if.sv
// comp_arbiter_if: lane request/response, comp issue/return and status signals
interface comp_arbiter_if
  import comp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
);
  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ-1:0] req_ready_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_a_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_b_i;
  logic comp_valid_o;
  logic comp_ready_i;
  logic [DATA_WIDTH-1:0] comp_data_a_o;
  logic [DATA_WIDTH-1:0] comp_data_b_o;
  logic comp_valid_i;
  logic comp_ready_o;
  logic [DATA_WIDTH-1:0] comp_data_i;
  logic [NUM_REQ-1:0] resp_valid_o;
  logic [NUM_REQ-1:0] resp_ready_i;
  logic [DATA_WIDTH-1:0] resp_data_o;
  logic [$clog2(TAG_DEPTH):0] inflight_o;
  logic err_o;
  modport slave (
    input req_valid_i, req_data_a_i, req_data_b_i, comp_ready_i, comp_valid_i, comp_data_i, resp_ready_i,
    output req_ready_o, comp_valid_o, comp_data_a_o, comp_data_b_o, comp_ready_o, resp_valid_o, resp_data_o,
    inflight_o, err_o
  );
  modport master (
    output req_valid_i, req_data_a_i, req_data_b_i, comp_ready_i, comp_valid_i, comp_data_i, resp_ready_i,
    input req_ready_o, comp_valid_o, comp_data_a_o, comp_data_b_o, comp_ready_o, resp_valid_o, resp_data_o,
    inflight_o, err_o
  );
endinterface

// File: rtl/comp_arbiter_tag_fifo.sv
// tag_fifo: synchronous FIFO of lane tags with occupancy counter, async reset
module tag_fifo
  import comp_arbiter_pkg::*;
#(
  parameter int W = $bits(lane_idx_t),
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic [W-1:0] i_din,
  input  logic i_pop,
  output logic [W-1:0] o_dout,
  output logic o_full,
  output logic o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= i_push ? r_wp + AW'(1) : r_wp;
      r_rp <= i_pop ? r_rp + AW'(1) : r_rp;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  assign o_dout = r_mem[r_rp];
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin sharing of one comp unit across NUM_REQ lanes,
// results routed back to the issuing lane through an in-order tag FIFO
module comp_arbiter
  import comp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input logic clk,
  input logic rst,
  comp_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] r_rr_ptr, w_grant, w_head;
  logic r_err;
  logic w_full, w_empty, w_can_issue, w_issue, w_ret;
  logic [$clog2(TAG_DEPTH):0] w_cnt;
  logic [DATA_WIDTH-1:0] w_a, w_b;
  // Scan downward so the lane closest to r_rr_ptr is the last (winning) assignment
  always_comb begin
    w_grant = r_rr_ptr;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (bus.req_valid_i[r_rr_ptr + IW'(k)]) w_grant = r_rr_ptr + IW'(k);
  end
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_can_issue && IW'(k) == w_grant) begin
        w_a = bus.req_data_a_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_b = bus.req_data_b_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  // full blocks issue even when a return pops in the same cycle
  assign w_can_issue = ~rst & (|bus.req_valid_i) & ~w_full;
  assign w_issue = w_can_issue & bus.comp_ready_i;
  assign bus.comp_valid_o = w_can_issue;
  assign bus.comp_data_a_o = w_a;
  assign bus.comp_data_b_o = w_b;
  assign bus.req_ready_o = w_issue ? (NUM_REQ'(1) << w_grant) & bus.req_valid_i : '0;
  assign bus.comp_ready_o = ~rst & ~w_empty & bus.resp_ready_i[w_head];
  assign w_ret = bus.comp_valid_i & bus.comp_ready_o;
  assign bus.resp_valid_o = (~rst & bus.comp_valid_i & ~w_empty) ? NUM_REQ'(1) << w_head : '0;
  assign bus.resp_data_o = bus.comp_data_i;
  assign bus.inflight_o = w_cnt;
  assign bus.err_o = r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rr_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      r_rr_ptr <= w_issue ? w_grant + IW'(1) : r_rr_ptr;
      r_err <= r_err | (bus.comp_valid_i & w_empty);
    end
  tag_fifo #(.W(IW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_issue),
    .i_din(w_grant),
    .i_pop(w_ret),
    .o_dout(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_cnt)
  );
endmodule

// File: tb/tb_comp_arbiter.sv
// tb_comp_arbiter: scoreboard bench acting as lanes and as an adder-style comp
module tb_comp_arbiter;
  typedef struct {
    int lane;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  comp_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(64), .TAG_DEPTH(4)) bus ();
  comp_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .TAG_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int rr = 0;
  int m_cnt = 0;
  logic m_err = 1'b0;
  logic [3:0] rdy = 4'hF;
  logic [63:0] opa [4];
  logic [63:0] opb [4];
  exp_t exp_q[$];
  logic [63:0] comp_q[$];
  task automatic idle();
    bus.req_valid_i = '0;
    bus.req_data_a_i = '0;
    bus.req_data_b_i = '0;
    bus.comp_ready_i = 1'b0;
    bus.comp_valid_i = 1'b0;
    bus.comp_data_i = '0;
    bus.resp_ready_i = '0;
  endtask
  task automatic rnd_ops();
    for (int k = 0; k < 4; k++) begin
      opa[k] = {$urandom, $urandom};
      opb[k] = {$urandom, $urandom};
    end
  endtask
  task automatic model_reset();
    rr = 0;
    m_cnt = 0;
    m_err = 1'b0;
    exp_q.delete();
    comp_q.delete();
  endtask
  // One cycle: lanes present v, comp ready cr, comp returns its oldest result if ret
  task automatic tick(input logic [3:0] v, input logic cr, input logic ret);
    int g, hl;
    logic evalid, efire, eret, dut_fire, dut_ret;
    logic [63:0] sum;
    bus.req_valid_i = v;
    bus.comp_ready_i = cr;
    bus.resp_ready_i = rdy;
    for (int k = 0; k < 4; k++) begin
      bus.req_data_a_i[k*64 +: 64] = opa[k];
      bus.req_data_b_i[k*64 +: 64] = opb[k];
    end
    bus.comp_valid_i = ret && comp_q.size() > 0;
    bus.comp_data_i = bus.comp_valid_i ? comp_q[0] : 64'd0;
    #1;
    g = rr;
    for (int i = 3; i >= 0; i--) if (v[(rr+i)%4]) g = (rr+i)%4;
    evalid = (v != 0) && m_cnt < 4;
    efire = evalid && cr;
    eret = 1'b0;
    n_tests++;
    if (bus.comp_valid_o !== evalid) begin
      n_fail++;
      $display("FAIL comp_valid_o: got %b expected %b", bus.comp_valid_o, evalid);
    end
    n_tests++;
    if (bus.req_ready_o !== (efire ? 4'(1 << g) : 4'd0)) begin
      n_fail++;
      $display("FAIL req_ready_o: got %b expected %b", bus.req_ready_o, efire ? 4'(1 << g) : 4'd0);
    end
    if (efire) begin
      n_tests++;
      if (bus.comp_data_a_o !== opa[g] || bus.comp_data_b_o !== opb[g]) begin
        n_fail++;
        $display("FAIL comp_data lane %0d: got %h/%h expected %h/%h", g, bus.comp_data_a_o, bus.comp_data_b_o, opa[g], opb[g]);
      end
    end
    n_tests++;
    if (bus.inflight_o !== 3'(m_cnt) || bus.err_o !== m_err) begin
      n_fail++;
      $display("FAIL status: got inflight %0d err %b expected %0d %b", bus.inflight_o, bus.err_o, m_cnt, m_err);
    end
    if (bus.comp_valid_i) begin
      hl = exp_q.size() > 0 ? exp_q[0].lane : 0;
      eret = exp_q.size() > 0 && rdy[hl];
      n_tests++;
      if (bus.resp_valid_o !== (exp_q.size() > 0 ? 4'(1 << hl) : 4'd0) || bus.comp_ready_o !== eret) begin
        n_fail++;
        $display("FAIL return: got resp_valid %b comp_ready %b expected lane %0d ready %b", bus.resp_valid_o, bus.comp_ready_o, hl, eret);
      end
      if (eret) begin
        n_tests++;
        if (bus.resp_data_o !== exp_q[0].data) begin
          n_fail++;
          $display("FAIL resp_data lane %0d: got %h expected %h", hl, bus.resp_data_o, exp_q[0].data);
        end
      end
    end
    dut_fire = bus.comp_valid_o & bus.comp_ready_i;
    dut_ret = bus.comp_valid_i & bus.comp_ready_o;
    sum = bus.comp_data_a_o + bus.comp_data_b_o;
    @(posedge clk);
    #1;
    if (dut_ret) void'(comp_q.pop_front());
    if (dut_fire) comp_q.push_back(sum);
    if (eret) begin
      void'(exp_q.pop_front());
      m_cnt--;
    end
    if (efire) begin
      exp_q.push_back('{g, opa[g] + opb[g]});
      rr = (g + 1) % 4;
      m_cnt++;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && comp_q.size() > 0; i++) tick(4'd0, 1'b1, 1'b1);
    n_tests++;
    if (bus.inflight_o !== 3'd0) begin
      n_fail++;
      $display("FAIL drain: got inflight %0d expected 0", bus.inflight_o);
    end
  endtask
  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.req_valid_i = 4'hF;
    bus.comp_ready_i = 1'b1;
    bus.comp_valid_i = 1'b1;
    bus.resp_ready_i = 4'hF;
    #3;
    n_tests++;
    if (bus.comp_valid_o !== 1'b0 || bus.req_ready_o !== 4'd0 || bus.comp_ready_o !== 1'b0 || bus.resp_valid_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b %b %b %b expected all zero", bus.comp_valid_o, bus.req_ready_o, bus.comp_ready_o, bus.resp_valid_o);
    end
    n_tests++;
    if (bus.inflight_o !== 3'd0 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got inflight %0d err %b expected 0 0", bus.inflight_o, bus.err_o);
    end
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    model_reset();
    tick(4'd0, 1'b1, 1'b0);
  endtask
  task automatic test_single_lane();
    opa[2] = 64'd5;
    opb[2] = 64'd7;
    tick(4'b0100, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    n_tests++;
    if (comp_q.size() != 1 || comp_q[0] !== 64'd12) begin
      n_fail++;
      $display("FAIL single_issue: got %0d results expected one of value 12", comp_q.size());
    end
    tick(4'b0000, 1'b1, 1'b1);
    n_tests++;
    if (bus.inflight_o !== 3'd0) begin
      n_fail++;
      $display("FAIL single_inflight: got %0d expected 0", bus.inflight_o);
    end
  endtask
  task automatic test_round_robin();
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    rnd_ops();
    for (int i = 0; i < 6; i++) tick(4'hF, 1'b1, 1'b1);
    drain();
  endtask
  task automatic test_fifo_full();
    rnd_ops();
    for (int i = 0; i < 5; i++) tick(4'b0001, 1'b1, 1'b0);
    tick(4'b0001, 1'b1, 1'b1);
    tick(4'b0001, 1'b1, 1'b0);
    drain();
  endtask
  task automatic test_backpressure();
    rnd_ops();
    tick(4'b0010, 1'b1, 1'b0);
    tick(4'b1000, 1'b1, 1'b0);
    rdy = 4'b1101;
    for (int i = 0; i < 3; i++) tick(4'd0, 1'b1, 1'b1);
    rdy = 4'hF;
    drain();
  endtask
  task automatic test_spurious();
    idle();
    bus.comp_valid_i = 1'b1;
    bus.comp_data_i = 64'hDEAD;
    bus.resp_ready_i = 4'hF;
    #1;
    n_tests++;
    if (bus.comp_ready_o !== 1'b0 || bus.resp_valid_o !== 4'd0) begin
      n_fail++;
      $display("FAIL spurious_handshake: got comp_ready %b resp_valid %b expected 0 0", bus.comp_ready_o, bus.resp_valid_o);
    end
    @(posedge clk);
    #1;
    bus.comp_valid_i = 1'b0;
    n_tests++;
    if (bus.err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_err: got %b expected 1", bus.err_o);
    end
    m_err = 1'b1;
    tick(4'd0, 1'b1, 1'b0);
    tick(4'd0, 1'b1, 1'b0);
  endtask
  task automatic test_reset_midop();
    rnd_ops();
    tick(4'b0001, 1'b1, 1'b0);
    tick(4'b0010, 1'b1, 1'b0);
    bus.req_valid_i = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.inflight_o !== 3'd0 || bus.err_o !== 1'b0 || bus.comp_valid_o !== 1'b0 || bus.req_ready_o !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got inflight %0d err %b comp_valid %b req_ready %b expected all zero", bus.inflight_o, bus.err_o, bus.comp_valid_o, bus.req_ready_o);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    tick(4'b1001, 1'b1, 1'b0);
    drain();
  endtask
  initial begin
    idle();
    test_reset();
    test_single_lane();
    test_round_robin();
    test_fifo_full();
    test_backpressure();
    test_spurious();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
